// File: rtl/pll_rst_seq_pkg.sv
// Shared types and defaults for the PLL reset/lock sequencer.
package pll_rst_seq_pkg;

    localparam int unsigned DEF_RST_CYCLES    = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT  = 4096;
    localparam int unsigned DEF_STABLE_CYCLES = 256;
    localparam int unsigned DEF_MAX_RETRY     = 3;
    localparam int unsigned DEF_CNT_W         = 16;
    localparam int unsigned RETRY_W           = 2;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_e;

    typedef struct packed {
        logic pll_rst;
        logic sys_rst;
        logic ready;
        logic fail;
    } ctl_t;

    // Output levels implied by a state; sys_rst stays high whenever pll_rst is.
    function automatic ctl_t decode_ctl(input state_e s);
        ctl_t c;
        c = '0;
        c.sys_rst = 1'b1;
        case (s)
            RESET_PLL: c.pll_rst = 1'b1;
            RUN: begin
                c.sys_rst = 1'b0;
                c.ready   = 1'b1;
            end
            FAIL: begin
                c.pll_rst = 1'b1;
                c.fail    = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
        return (v == '1) ? v : v + RETRY_W'(1);
    endfunction

endpackage

// File: rtl/pll_rst_seq_sync2.sv
// Two-flop synchronizer with asynchronous active-low clear.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset/lock sequencer: pulses pll_rst, supervises lock with retries,
// and releases sys_rst once lock has been stable for STABLE_CYCLES.
module pll_rst_seq
    import pll_rst_seq_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned MAX_RETRY     = DEF_MAX_RETRY,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pll_locked,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic               ready,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam logic [CNT_W-1:0]   RST_LOAD     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LOAD  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRY);

    state_e             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [RETRY_W-1:0] retry_nxt;
    logic               lk;
    logic               cnt_zero;
    ctl_t               ctl_nxt;

    sync2 u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lk)
    );

    assign cnt_zero = (cnt == '0);

    // Next-state, counter reload and retry bookkeeping.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        retry_nxt = retry_cnt;
        case (state)
            RESET_PLL: begin
                if (cnt_zero) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = TIMEOUT_LOAD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (lk) begin
                    state_nxt = STABLE;
                    cnt_nxt   = STABLE_LOAD;
                end else if (cnt_zero) begin
                    if (retry_cnt == RETRY_MAX) begin
                        state_nxt = FAIL;
                    end else begin
                        state_nxt = RESET_PLL;
                        cnt_nxt   = RST_LOAD;
                        retry_nxt = sat_inc(retry_cnt);
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            STABLE: begin
                // A lock dropout while settling is a failed attempt.
                if (!lk) begin
                    if (retry_cnt == RETRY_MAX) begin
                        state_nxt = FAIL;
                    end else begin
                        state_nxt = RESET_PLL;
                        cnt_nxt   = RST_LOAD;
                        retry_nxt = sat_inc(retry_cnt);
                    end
                end else if (cnt_zero) begin
                    state_nxt = RUN;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            RUN: begin
                // Lock loss after a good start begins a fresh sequence.
                if (!lk) begin
                    state_nxt = RESET_PLL;
                    cnt_nxt   = RST_LOAD;
                    retry_nxt = '0;
                end
            end
            FAIL: ;
            default: begin
                state_nxt = RESET_PLL;
                cnt_nxt   = RST_LOAD;
            end
        endcase
        ctl_nxt = decode_ctl(state_nxt);
    end

    // State, counter and outputs registered from the next-state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RESET_PLL;
            cnt       <= RST_LOAD;
            retry_cnt <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            retry_cnt <= retry_nxt;
            pll_rst   <= ctl_nxt.pll_rst;
            sys_rst   <= ctl_nxt.sys_rst;
            ready     <= ctl_nxt.ready;
            fail      <= ctl_nxt.fail;
        end
    end

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq: scenario table, hand-written corner sequences and
// random lock activity, all checked against a cycle-level reference model.
module tb_pll_rst_seq;

    localparam int RST = 16;
    localparam int TO  = 4096;
    localparam int STB = 256;
    localparam int MR  = 3;

    localparam int PH_HOLD   = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_SETTLE = 2;
    localparam int PH_GO     = 3;
    localparam int PH_DEAD   = 4;

    logic       clk;
    logic       rst_n;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic [1:0] retry_cnt;

    int total;
    int bad;

    pll_rst_seq #(
        .RST_CYCLES    (RST),
        .LOCK_TIMEOUT  (TO),
        .STABLE_CYCLES (STB),
        .MAX_RETRY     (MR),
        .CNT_W         (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .fail       (fail),
        .retry_cnt  (retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase plus cycles spent in it, lock seen two edges late.
    int   m_phase;
    int   m_elapsed;
    int   m_fails;
    logic m_h0;
    logic m_h1;

    function automatic void model_step(input int ph, input int el, input int fl, input logic l,
                                       output int nph, output int nel, output int nfl);
        int e1;
        e1  = el + 1;
        nph = ph;
        nel = e1;
        nfl = fl;
        case (ph)
            PH_HOLD: if (e1 == RST) begin nph = PH_WAIT; nel = 0; end
            PH_WAIT: begin
                if (l) begin
                    nph = PH_SETTLE; nel = 0;
                end else if (e1 == TO) begin
                    nel = 0;
                    if (fl >= MR) nph = PH_DEAD;
                    else begin nph = PH_HOLD; nfl = fl + 1; end
                end
            end
            PH_SETTLE: begin
                if (!l) begin
                    nel = 0;
                    if (fl >= MR) nph = PH_DEAD;
                    else begin nph = PH_HOLD; nfl = fl + 1; end
                end else if (e1 == STB) begin
                    nph = PH_GO; nel = 0;
                end
            end
            PH_GO: if (!l) begin nph = PH_HOLD; nel = 0; nfl = 0; end
            default: ;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int nph, nel, nfl;
        if (!rst_n) begin
            m_phase   <= PH_HOLD;
            m_elapsed <= 0;
            m_fails   <= 0;
            m_h0      <= 1'b0;
            m_h1      <= 1'b0;
        end else begin
            model_step(m_phase, m_elapsed, m_fails, m_h1, nph, nel, nfl);
            m_phase   <= nph;
            m_elapsed <= nel;
            m_fails   <= nfl;
            m_h1      <= m_h0;
            m_h0      <= pll_locked;
        end
    end

    function automatic logic [5:0] model_out();
        logic [5:0] v;
        v[5]   = (m_phase == PH_HOLD) || (m_phase == PH_DEAD);
        v[4]   = (m_phase != PH_GO);
        v[3]   = (m_phase == PH_GO);
        v[2]   = (m_phase == PH_DEAD);
        v[1:0] = 2'(m_fails);
        return v;
    endfunction

    // Advance one cycle and compare every output against the model.
    task automatic tick();
        logic [5:0] got;
        logic [5:0] want;
        @(negedge clk);
        got  = {pll_rst, sys_rst, ready, fail, retry_cnt};
        want = model_out();
        total++;
        if (got !== want || (pll_rst === 1'b1 && sys_rst === 1'b0)) begin
            bad++;
            $display("FAIL model t=%0t {pll_rst,sys_rst,ready,fail,retry} got=%b want=%b",
                     $time, got, want);
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic chk_range(input string name, input int got, input int lo, input int hi);
        total++;
        if (got < lo || got > hi) begin
            bad++;
            $display("FAIL %s: got %0d want %0d..%0d", name, got, lo, hi);
        end
    endtask

    // Count cycles until pll_rst (sel=0) or sys_rst (sel=1) reaches val.
    task automatic wait_sig(input int sel, input logic val, input int budget, output int n);
        logic s;
        n = 0;
        do begin
            tick();
            n++;
            s = (sel == 0) ? pll_rst : sys_rst;
        end while (s !== val && n < budget);
    endtask

    task automatic do_reset();
        pll_locked = 1'b0;
        rst_n      = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        int         n_to;
        logic       exp_ready;
        logic       exp_fail;
        logic [1:0] exp_retry;
    } vec_t;

    // Lock stays low for n_to attempts, then rises 10 cycles into the next.
    task automatic run_case(input vec_t v);
        int n;
        do_reset();
        for (int a = 0; a <= v.n_to && a <= MR; a++) begin
            wait_sig(0, 1'b0, RST + 8, n);
            chk("pll_rst_pulse", n, RST);
            if (a < v.n_to) begin
                wait_sig(0, 1'b1, TO + 8, n);
                chk("wait_window", n, TO);
            end else begin
                repeat (10) tick();
                pll_locked = 1'b1;
                wait_sig(1, 1'b0, STB + 20, n);
                chk_range("lock_to_sys_rst", n, 2 + STB, 2 + STB + 2);
            end
        end
        tick();
        chk("case_ready", int'(ready), int'(v.exp_ready));
        chk("case_fail", int'(fail), int'(v.exp_fail));
        chk("case_retry", int'(retry_cnt), int'(v.exp_retry));
        chk("case_sys_rst", int'(sys_rst), int'(!v.exp_ready));
        chk("case_pll_rst", int'(pll_rst), int'(v.exp_fail));
    endtask

    initial begin
        vec_t vecs[4];
        int   n;
        total      = 0;
        bad        = 0;
        rst_n      = 1'b1;
        pll_locked = 1'b0;
        vecs[0] = '{n_to: 0, exp_ready: 1'b1, exp_fail: 1'b0, exp_retry: 2'd0};
        vecs[1] = '{n_to: 1, exp_ready: 1'b1, exp_fail: 1'b0, exp_retry: 2'd1};
        vecs[2] = '{n_to: 2, exp_ready: 1'b1, exp_fail: 1'b0, exp_retry: 2'd2};
        vecs[3] = '{n_to: 4, exp_ready: 1'b0, exp_fail: 1'b1, exp_retry: 2'd3};
        #2 rst_n = 1'b0;

        tick();
        tick();
        chk("rst_pll_rst", int'(pll_rst), 1);
        chk("rst_sys_rst", int'(sys_rst), 1);
        chk("rst_ready", int'(ready), 0);
        chk("rst_fail", int'(fail), 0);
        chk("rst_retry", int'(retry_cnt), 0);

        foreach (vecs[i]) run_case(vecs[i]);

        // FAIL is terminal whatever the lock input does.
        for (int c = 0; c < 10000; c++) begin
            pll_locked = 1'($urandom_range(0, 1));
            tick();
        end
        chk("fail_hold", int'(fail), 1);
        chk("fail_hold_pll_rst", int'(pll_rst), 1);

        // One-cycle lock glitch while settling.
        do_reset();
        wait_sig(0, 1'b0, RST + 8, n);
        repeat (10) tick();
        pll_locked = 1'b1;
        repeat (2 + 100) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        wait_sig(0, 1'b1, 10, n);
        chk("glitch_react", 1 + n, 3);
        chk("glitch_retry", int'(retry_cnt), 1);
        wait_sig(0, 1'b0, RST + 8, n);
        chk("glitch_pll_rst_pulse", n, RST);
        wait_sig(1, 1'b0, STB + 20, n);
        chk("glitch_full_stable", n, 1 + STB);
        chk("glitch_ready", int'(ready), 1);

        // Lock loss in RUN restarts with a cleared retry count.
        pll_locked = 1'b0;
        wait_sig(1, 1'b1, 10, n);
        chk("runloss_react", n, 3);
        chk("runloss_ready", int'(ready), 0);
        chk("runloss_retry", int'(retry_cnt), 0);
        wait_sig(0, 1'b0, RST + 8, n);
        chk("runloss_pll_rst_pulse", n, RST);
        repeat (10) tick();
        pll_locked = 1'b1;
        wait_sig(1, 1'b0, STB + 20, n);
        chk_range("runloss_relock", n, 2 + STB, 2 + STB + 2);
        chk("runloss_ready_again", int'(ready), 1);

        // Asynchronous reset in WAIT_LOCK with a nonzero retry count.
        do_reset();
        wait_sig(0, 1'b0, RST + 8, n);
        repeat (10) tick();
        pll_locked = 1'b1;
        repeat (50) tick();
        pll_locked = 1'b0;
        wait_sig(0, 1'b1, 10, n);
        wait_sig(0, 1'b0, RST + 8, n);
        repeat (20) tick();
        chk("async_pre_retry", int'(retry_cnt), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_pll_rst", int'(pll_rst), 1);
        chk("async_sys_rst", int'(sys_rst), 1);
        chk("async_retry", int'(retry_cnt), 0);
        chk("async_ready", int'(ready), 0);
        tick();
        tick();
        #2 rst_n = 1'b1;
        wait_sig(0, 1'b0, RST + 8, n);
        chk("async_pll_rst_pulse", n, RST);

        // Random lock activity with occasional resets.
        do_reset();
        for (int c = 0; c < 15000; c++) begin
            if (pll_locked) begin
                if ($urandom_range(0, 149) == 0) pll_locked = 1'b0;
            end else begin
                if ($urandom_range(0, 29) == 0) pll_locked = 1'b1;
            end
            if ($urandom_range(0, 4999) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
